// File: rtl/dm_arbiter_if.sv
// Bundle shared between the two data-memory requesters, the arbiter and the memory.
// slave  : arbiter side (takes requests, drives the memory bus)
// master : environment side (requesters + memory)
interface dm_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // port 0 : CPU load/store path
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    // port 1 : loader/debug path
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    // single-port synchronous memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // status
    logic              busy;
    logic [1:0]        watch_stat;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, watch_stat
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, watch_stat
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory.
// Each access walks IDLE -> ISSUE -> RESP; the ack pulse lands in the following IDLE
// cycle, which may already grant the other port.
module dm_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_RESP    = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_is_read;
    logic [1:0]        r_ack;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_mem_en_next;
    logic              w_mem_we_next;
    logic [ADDR_W-1:0] w_mem_addr_next;
    logic [DATA_W-1:0] w_mem_wdata_next;
    logic              w_owner_next;
    logic              w_last_owner_next;
    logic              w_is_read_next;
    logic [1:0]        w_ack_next;
    logic [DATA_W-1:0] w_rdata0_next;
    logic [DATA_W-1:0] w_rdata1_next;

    logic [1:0]        w_elig;
    logic              w_grant1;

    // A port still holding req during its own ack cycle is not eligible again.
    assign w_elig = {bus.req1 & ~r_ack[1], bus.req0 & ~r_ack[0]};

    // Port 1 wins when it is alone, or on a tie when port 0 owned the last access.
    assign w_grant1 = w_elig[1] & (~w_elig[0] | ~r_last_owner);

    // Next-state and next-register values; defaults hold everything and drop enables/acks.
    always_comb begin
        w_state_next      = r_state;
        w_mem_en_next     = 1'b0;
        w_mem_we_next     = 1'b0;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_is_read_next    = r_is_read;
        w_ack_next        = 2'b00;
        w_rdata0_next     = r_rdata0;
        w_rdata1_next     = r_rdata1;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_state_next      = S_ISSUE;
                    w_mem_en_next     = 1'b1;
                    w_owner_next      = w_grant1;
                    w_last_owner_next = w_grant1;
                    if (w_grant1) begin
                        w_mem_we_next    = bus.we1;
                        w_mem_addr_next  = bus.addr1;
                        w_mem_wdata_next = bus.wdata1;
                        w_is_read_next   = ~bus.we1;
                    end else begin
                        w_mem_we_next    = bus.we0;
                        w_mem_addr_next  = bus.addr0;
                        w_mem_wdata_next = bus.wdata0;
                        w_is_read_next   = ~bus.we0;
                    end
                end
            end
            S_ISSUE: begin
                // memory samples the access at the edge leaving this state
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (r_is_read) begin
                    if (r_owner) begin
                        w_rdata1_next = bus.mem_rdata;
                    end else begin
                        w_rdata0_next = bus.mem_rdata;
                    end
                end
                w_ack_next[r_owner] = 1'b1;
                w_state_next        = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered memory bus, ownership and requester outputs; reset kills any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_is_read    <= 1'b0;
            r_ack        <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_mem_en     <= w_mem_en_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_is_read    <= w_is_read_next;
            r_ack        <= w_ack_next;
            r_rdata0     <= w_rdata0_next;
            r_rdata1     <= w_rdata1_next;
        end
    end

    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.ack0       = r_ack[0];
    assign bus.ack1       = r_ack[1];
    assign bus.rdata0     = r_rdata0;
    assign bus.rdata1     = r_rdata1;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.watch_stat = r_state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port memory behind it.
module tb_dm_arbiter;

    logic clk;
    logic rst;

    dm_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus_if ();

    dm_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model with a backdoor write port for preloading
    logic [31:0] mem [1024];
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus_if.mem_en) begin
            if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
            else               bus_if.mem_rdata <= mem[bus_if.mem_addr];
        end
    end

    // activity monitors sampled on the falling edge
    int         n_en, n_we, n_ack0, n_ack1, n_both;
    bit         recording;
    logic [9:0] grants [$];

    initial begin
        n_en = 0; n_we = 0; n_ack0 = 0; n_ack1 = 0; n_both = 0; recording = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.mem_en)                n_en   <= n_en + 1;
            if (bus_if.mem_we)                n_we   <= n_we + 1;
            if (bus_if.ack0)                  n_ack0 <= n_ack0 + 1;
            if (bus_if.ack1)                  n_ack1 <= n_ack1 + 1;
            if (bus_if.ack0 && bus_if.ack1)   n_both <= n_both + 1;
            if (recording && bus_if.watch_stat == 2'b01) grants.push_back(bus_if.mem_addr);
        end
    end

    int n_cmp;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        step();
        bd_we = 1'b0;
    endtask

    // One complete transaction on port p; checks the 3-edge latency and returns to idle.
    task automatic run_txn(input bit p, input logic we, input logic [9:0] a,
                           input logic [31:0] d, input string tag);
        int  lat;
        bit  got;
        if (p) begin
            bus_if.req1 = 1'b1; bus_if.we1 = we; bus_if.addr1 = a; bus_if.wdata1 = d;
        end else begin
            bus_if.req0 = 1'b1; bus_if.we0 = we; bus_if.addr0 = a; bus_if.wdata0 = d;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            step();
            lat++;
            got = p ? bus_if.ack1 : bus_if.ack0;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        $display("txn %s port=%0d we=%0b addr=%h wdata=%h latency=%0d", tag, p, we, a, d, lat);
        if (p) bus_if.req1 = 1'b0;
        else   bus_if.req0 = 1'b0;
        step();
    endtask

    initial begin
        int w0, a1, e0, cyc;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        bus_if.req0 = 1'b0; bus_if.we0 = 1'b0; bus_if.addr0 = '0; bus_if.wdata0 = '0;
        bus_if.req1 = 1'b0; bus_if.we1 = 1'b0; bus_if.addr1 = '0; bus_if.wdata1 = '0;

        preload(10'h001, 32'h11111111);
        preload(10'h002, 32'h22222222);
        preload(10'h003, 32'hA5A5A5A5);
        preload(10'h010, 32'hCAFEF00D);
        preload(10'h005, 32'h00000000);

        // reset state
        chk("rst_state", 32'(bus_if.watch_stat), 32'd0);
        chk("rst_busy",  32'(bus_if.busy), 32'd0);
        chk("rst_mem_en", 32'(bus_if.mem_en), 32'd0);
        chk("rst_ack0",  32'(bus_if.ack0), 32'd0);
        chk("rst_rdata0", bus_if.rdata0, 32'd0);
        chk("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        rst = 1'b0;
        step();

        // 1: port 0 write then read
        w0 = n_we; a1 = n_ack1;
        run_txn(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, "t1_wr");
        chk("t1_we_pulse", 32'(n_we - w0), 32'd1);
        run_txn(1'b0, 1'b0, 10'h005, 32'h0, "t1_rd");
        chk("t1_rdata0", bus_if.rdata0, 32'hDEADBEEF);
        chk("t1_we_total", 32'(n_we - w0), 32'd1);
        chk("t1_no_ack1", 32'(n_ack1 - a1), 32'd0);

        // 2: simultaneous requests right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus_if.req0 = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 10'h001;
        bus_if.req1 = 1'b1; bus_if.we1 = 1'b0; bus_if.addr1 = 10'h002;
        step();
        chk("t2_issue0", 32'(bus_if.watch_stat), 32'd1);
        chk("t2_addr0", 32'(bus_if.mem_addr), 32'h001);
        step();
        step();
        chk("t2_ack0", 32'(bus_if.ack0), 32'd1);
        chk("t2_ack1_lo", 32'(bus_if.ack1), 32'd0);
        chk("t2_rdata0", bus_if.rdata0, 32'h11111111);
        bus_if.req0 = 1'b0;
        step();
        chk("t2_issue1", 32'(bus_if.watch_stat), 32'd1);
        chk("t2_addr1", 32'(bus_if.mem_addr), 32'h002);
        step();
        step();
        chk("t2_ack1", 32'(bus_if.ack1), 32'd1);
        chk("t2_rdata1", bus_if.rdata1, 32'h22222222);
        $display("txn t2 simultaneous rdata0=%h rdata1=%h", bus_if.rdata0, bus_if.rdata1);
        bus_if.req1 = 1'b0;
        step();

        // 3: continuous contention
        grants.delete();
        recording = 1'b1;
        bus_if.req0 = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 10'h020;
        bus_if.req1 = 1'b1; bus_if.we1 = 1'b0; bus_if.addr1 = 10'h021;
        cyc = 0;
        while (grants.size() < 8 && cyc < 60) begin
            step();
            cyc++;
        end
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        recording = 1'b0;
        chk("t3_count", 32'(grants.size()), 32'd8);
        for (int i = 0; i < grants.size() && i < 8; i++) begin
            chk($sformatf("t3_grant%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'h020 : 32'h021);
            $display("txn t3 grant %0d addr=%h", i, grants[i]);
        end
        cyc = 0;
        while ((bus_if.busy || bus_if.ack0 || bus_if.ack1) && cyc < 10) begin
            step();
            cyc++;
        end
        chk("t3_drain", 32'(bus_if.busy), 32'd0);
        chk("t3_no_both_ack", 32'(n_both), 32'd0);

        // 4: request held through its ack cycle
        e0 = n_en;
        bus_if.req0 = 1'b1; bus_if.we0 = 1'b0; bus_if.addr0 = 10'h030;
        cyc = 0;
        while (!bus_if.ack0 && cyc < 10) begin
            step();
            cyc++;
        end
        chk("t4_lat", 32'(cyc), 32'd3);
        step();
        bus_if.req0 = 1'b0;
        step();
        step();
        chk("t4_one_access", 32'(n_en - e0), 32'd1);
        chk("t4_idle", 32'(bus_if.watch_stat), 32'd0);
        $display("txn t4 held request accesses=%0d", n_en - e0);

        // 5: reset during the ISSUE cycle of a write
        a1 = n_ack1;
        bus_if.req1 = 1'b1; bus_if.we1 = 1'b1; bus_if.addr1 = 10'h010; bus_if.wdata1 = 32'h12345678;
        step();
        chk("t5_issue", 32'(bus_if.watch_stat), 32'd1);
        chk("t5_we_hi", 32'(bus_if.mem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_we_drop", 32'(bus_if.mem_we), 32'd0);
        chk("t5_en_drop", 32'(bus_if.mem_en), 32'd0);
        chk("t5_state", 32'(bus_if.watch_stat), 32'd0);
        bus_if.req1 = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("t5_no_ack1", 32'(n_ack1 - a1), 32'd0);
        chk("t5_rdata0", bus_if.rdata0, 32'd0);
        chk("t5_rdata1", bus_if.rdata1, 32'd0);
        run_txn(1'b1, 1'b0, 10'h010, 32'h0, "t5_rd");
        chk("t5_old_data", bus_if.rdata1, 32'hCAFEF00D);

        // 6: a write leaves rdata untouched
        run_txn(1'b1, 1'b0, 10'h003, 32'h0, "t6_rd");
        chk("t6_rd1", bus_if.rdata1, 32'hA5A5A5A5);
        run_txn(1'b1, 1'b1, 10'h003, 32'h0, "t6_wr");
        chk("t6_hold", bus_if.rdata1, 32'hA5A5A5A5);
        run_txn(1'b1, 1'b0, 10'h003, 32'h0, "t6_rd2");
        chk("t6_rd2", bus_if.rdata1, 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
